// File: rtl/div_if.sv
// Request/response bundle between the EX stage and the iterative divider.
// Signal directions in the names are from the divider's point of view.
//   master : requester (core EX stage) drives start/op/operands/rd/flush
//   slave  : divider drives busy/done/result/rd tag of the completed op
interface div_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
);
  logic                  div_start_i;
  logic [1:0]            div_op_i;
  logic [DATA_W-1:0]     div_dividend_i;
  logic [DATA_W-1:0]     div_divisor_i;
  logic [REG_ADDR_W-1:0] div_rd_i;
  logic                  div_flush_i;
  logic                  div_busy_o;
  logic                  div_done_o;
  logic [DATA_W-1:0]     div_result_o;
  logic [REG_ADDR_W-1:0] div_rd_o;

  modport master (
    output div_start_i,
    output div_op_i,
    output div_dividend_i,
    output div_divisor_i,
    output div_rd_i,
    output div_flush_i,
    input  div_busy_o,
    input  div_done_o,
    input  div_result_o,
    input  div_rd_o
  );

  modport slave (
    input  div_start_i,
    input  div_op_i,
    input  div_dividend_i,
    input  div_divisor_i,
    input  div_rd_i,
    input  div_flush_i,
    output div_busy_o,
    output div_done_o,
    output div_result_o,
    output div_rd_o
  );
endinterface

// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One request at a time; the core stalls from request until done.
//
// Ports:
//   clk    core clock
//   rst_n  synchronous reset, active-low
//   bus    div_if.slave:
//            div_start_i     request, sampled only when idle
//            div_op_i        funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//            div_dividend_i  rs1 value
//            div_divisor_i   rs2 value
//            div_rd_i        destination register tag
//            div_flush_i     abort the in-flight op, return to idle
//            div_busy_o      high in every state except idle
//            div_done_o      one-cycle pulse, result/rd valid
//            div_result_o    quotient or remainder (held until next result)
//            div_rd_o        tag of the completed op (held until next result)
//
// Build option:
//   DIV_EARLY_OUT_EN  when defined, divide-by-zero and signed overflow skip the
//                     iteration phase and complete two cycles after the request.
module div_seq #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input logic  clk,
  input logic  rst_n,
  div_if.slave bus
);

  localparam int unsigned CntW = $clog2(DATA_W) + 1;
  localparam logic [DATA_W-1:0] MinNeg = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e                state_q;
  logic                  rem_sel_q;     // op[1]: 1 selects remainder
  logic [REG_ADDR_W-1:0] rd_tag_q;
  logic                  dvd_neg_q;
  logic                  dvs_neg_q;
  logic                  div_zero_q;
  logic                  overflow_q;
  logic [DATA_W-1:0]     dividend_q;    // raw rs1, needed by the special cases
  logic [DATA_W-1:0]     divisor_q;     // |divisor|
  logic [DATA_W-1:0]     quo_q;         // dividend bits shift out, quotient bits in
  logic [DATA_W:0]       rem_q;         // last trial difference incl. sign bit
  logic [CntW-1:0]       count_q;
  logic                  busy_q;
  logic                  done_q;
  logic [DATA_W-1:0]     result_q;
  logic [REG_ADDR_W-1:0] rd_out_q;

  // Request decode (idle only)
  logic              signed_op;
  logic              in_dvd_neg;
  logic              in_dvs_neg;
  logic [DATA_W-1:0] in_dvd_abs;
  logic [DATA_W-1:0] in_dvs_abs;
  logic              in_div_zero;
  logic              in_overflow;
  logic              skip_calc;

  assign signed_op   = ~bus.div_op_i[0];
  assign in_dvd_neg  = signed_op & bus.div_dividend_i[DATA_W-1];
  assign in_dvs_neg  = signed_op & bus.div_divisor_i[DATA_W-1];
  assign in_dvd_abs  = in_dvd_neg ? -bus.div_dividend_i : bus.div_dividend_i;
  assign in_dvs_abs  = in_dvs_neg ? -bus.div_divisor_i : bus.div_divisor_i;
  assign in_div_zero = (bus.div_divisor_i == '0);
  assign in_overflow = signed_op & (bus.div_dividend_i == MinNeg) & (bus.div_divisor_i == '1);

`ifdef DIV_EARLY_OUT_EN
  assign skip_calc = in_div_zero | in_overflow;
`else
  assign skip_calc = 1'b0;
`endif

  // Iteration datapath. A failed trial is not written back as the restored
  // value; instead the divisor is added back at the start of the next cycle,
  // so rem_q always holds the raw difference with its sign bit.
  logic [DATA_W-1:0] partial;
  logic [DATA_W:0]   trial;

  assign partial = rem_q[DATA_W] ? (rem_q[DATA_W-1:0] + divisor_q) : rem_q[DATA_W-1:0];
  assign trial   = {partial, quo_q[DATA_W-1]} - {1'b0, divisor_q};

  // Sign fix-up and special-case override
  logic [DATA_W-1:0] quo_signed;
  logic [DATA_W-1:0] rem_signed;
  logic [DATA_W-1:0] fix_result;

  assign quo_signed = (dvd_neg_q ^ dvs_neg_q) ? -quo_q : quo_q;
  assign rem_signed = dvd_neg_q ? -partial : partial;

  always_comb begin
    fix_result = rem_sel_q ? rem_signed : quo_signed;
    if (div_zero_q) begin
      fix_result = rem_sel_q ? dividend_q : '1;
    end else if (overflow_q) begin
      fix_result = rem_sel_q ? '0 : dividend_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rem_sel_q  <= 1'b0;
      rd_tag_q   <= '0;
      dvd_neg_q  <= 1'b0;
      dvs_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      overflow_q <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      rd_out_q   <= '0;
    end else if (bus.div_flush_i) begin
      // Abort wins over start and completion; result/rd keep their old values
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (bus.div_start_i) begin
            rem_sel_q  <= bus.div_op_i[1];
            rd_tag_q   <= bus.div_rd_i;
            dvd_neg_q  <= in_dvd_neg;
            dvs_neg_q  <= in_dvs_neg;
            div_zero_q <= in_div_zero;
            overflow_q <= in_overflow;
            dividend_q <= bus.div_dividend_i;
            divisor_q  <= in_dvs_abs;
            quo_q      <= in_dvd_abs;
            rem_q      <= '0;
            count_q    <= '0;
            busy_q     <= 1'b1;
            state_q    <= skip_calc ? StFix : StCalc;
          end
        end
        StCalc: begin
          rem_q   <= trial;
          quo_q   <= {quo_q[DATA_W-2:0], ~trial[DATA_W]};
          count_q <= count_q + 1'b1;
          if (count_q == LastCnt) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          result_q <= fix_result;
          rd_out_q <= rd_tag_q;
          done_q   <= 1'b1;
          state_q  <= StDone;
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.div_busy_o   = busy_q;
  assign bus.div_done_o   = done_q;
  assign bus.div_result_o = result_q;
  assign bus.div_rd_o     = rd_out_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: reset, arithmetic, special cases, latency,
// flush, start-while-busy, mid-op reset, then randomized operands against a
// small reference model. Inputs change and outputs are sampled on negedge.
module tb_div_seq;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [31:0] last_result;
  logic [4:0]  last_rd;

  div_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

  div_seq #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'h0 : 32'h8000_0000;
    case (op)
      2'b00:   return 32'($signed(a) / $signed(b));
      2'b01:   return a / b;
      2'b10:   return 32'($signed(a) % $signed(b));
      default: return a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    int lat;
    lat = 34;
`ifdef DIV_EARLY_OUT_EN
    if (b == 32'h0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) lat = 2;
`endif
    return lat;
  endfunction

  // Caller is at a negedge with the divider idle.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int cyc;
    bit busy_ok;
    bus.div_start_i    = 1'b1;
    bus.div_op_i       = op;
    bus.div_dividend_i = a;
    bus.div_divisor_i  = b;
    bus.div_rd_i       = rd;
    @(negedge clk);
    // Scramble inputs so the op must have been latched
    bus.div_start_i    = 1'b0;
    bus.div_op_i       = 2'($urandom);
    bus.div_dividend_i = $urandom;
    bus.div_divisor_i  = $urandom;
    bus.div_rd_i       = 5'($urandom);
    cyc     = 1;
    busy_ok = 1'b1;
    while (!bus.div_done_o && cyc < 60) begin
      if (!bus.div_busy_o) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    if (!bus.div_busy_o) busy_ok = 1'b0;
    check({tag, " latency"}, 32'(cyc), 32'(exp_latency(op, a, b)));
    check({tag, " result"}, bus.div_result_o, exp);
    check({tag, " rd"}, {27'h0, bus.div_rd_o}, {27'h0, rd});
    check({tag, " busy held"}, {31'h0, busy_ok}, 32'h1);
    last_result = exp;
    last_rd     = rd;
    @(negedge clk);
    check({tag, " done/busy after"}, {30'h0, bus.div_done_o, bus.div_busy_o}, 32'h0);
  endtask

  initial begin
    int  cyc;
    bit  saw_done;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    n_checks = 0;
    n_fail   = 0;
    rst_n              = 1'b0;
    bus.div_start_i    = 1'b0;
    bus.div_op_i       = 2'b00;
    bus.div_dividend_i = 32'h0;
    bus.div_divisor_i  = 32'h0;
    bus.div_rd_i       = 5'h0;
    bus.div_flush_i    = 1'b0;

    repeat (3) @(negedge clk);
    check("reset busy", {31'h0, bus.div_busy_o}, 32'h0);
    check("reset done", {31'h0, bus.div_done_o}, 32'h0);
    check("reset result", bus.div_result_o, 32'h0);
    check("reset rd", {27'h0, bus.div_rd_o}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Arithmetic
    run_op("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'h2,         5'd5,  32'hFFFF_FFFD);
    run_op("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'h2,         5'd6,  32'hFFFF_FFFF);
    run_op("remu_100_7", 2'b11, 32'd100,       32'd7,         5'd9,  32'd2);
    run_op("divu_max_3", 2'b01, 32'hFFFF_FFFF, 32'd3,         5'd10, 32'h5555_5555);
    run_op("div_20_m3",  2'b00, 32'd20,        32'hFFFF_FFFD, 5'd11, 32'hFFFF_FFFA);
    run_op("rem_20_m3",  2'b10, 32'd20,        32'hFFFF_FFFD, 5'd12, 32'd2);
    run_op("divu_min_m1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0);
    // Special cases
    run_op("divu_5_0",   2'b01, 32'd5,         32'h0,         5'd14, 32'hFFFF_FFFF);
    run_op("rem_5_0",    2'b10, 32'd5,         32'h0,         5'd15, 32'd5);
    run_op("div_m8_0",   2'b00, 32'hFFFF_FFF8, 32'h0,         5'd16, 32'hFFFF_FFFF);
    run_op("rem_m8_0",   2'b10, 32'hFFFF_FFF8, 32'h0,         5'd17, 32'hFFFF_FFF8);
    run_op("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000);
    run_op("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h0);

    // Flush beats start in idle
    bus.div_start_i = 1'b1;
    bus.div_flush_i = 1'b1;
    bus.div_op_i    = 2'b01;
    bus.div_dividend_i = 32'd9;
    bus.div_divisor_i  = 32'd3;
    @(negedge clk);
    bus.div_start_i = 1'b0;
    bus.div_flush_i = 1'b0;
    check("flush over start busy", {31'h0, bus.div_busy_o}, 32'h0);

    // Flush mid-op at N+10
    bus.div_start_i    = 1'b1;
    bus.div_op_i       = 2'b00;
    bus.div_dividend_i = 32'd1000;
    bus.div_divisor_i  = 32'd3;
    bus.div_rd_i       = 5'd7;
    @(negedge clk);
    bus.div_start_i = 1'b0;
    saw_done = 1'b0;
    for (int k = 1; k < 10; k++) begin
      if (bus.div_done_o) saw_done = 1'b1;
      @(negedge clk);
    end
    bus.div_flush_i = 1'b1;
    @(negedge clk);
    bus.div_flush_i = 1'b0;
    if (bus.div_done_o) saw_done = 1'b1;
    check("flush busy low", {31'h0, bus.div_busy_o}, 32'h0);
    check("flush no done", {31'h0, saw_done}, 32'h0);
    check("flush result kept", bus.div_result_o, last_result);
    check("flush rd kept", {27'h0, bus.div_rd_o}, {27'h0, last_rd});
    run_op("post_flush", 2'b00, 32'd1000, 32'd3, 5'd7, 32'd333);

    // Start held high through done; a second op begins after the idle cycle
    bus.div_start_i    = 1'b1;
    bus.div_op_i       = 2'b01;
    bus.div_dividend_i = 32'd100;
    bus.div_divisor_i  = 32'd7;
    bus.div_rd_i       = 5'd3;
    @(negedge clk);
    cyc = 1;
    while (!bus.div_done_o && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check("hold latency", 32'(cyc), 32'd34);
    check("hold result", bus.div_result_o, 32'd14);
    check("hold rd", {27'h0, bus.div_rd_o}, 32'd3);
    @(negedge clk);
    check("hold idle gap", {31'h0, bus.div_busy_o}, 32'h0);
    @(negedge clk);
    check("hold restart busy", {31'h0, bus.div_busy_o}, 32'h1);
    bus.div_start_i = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset busy", {31'h0, bus.div_busy_o}, 32'h0);
    check("midreset done", {31'h0, bus.div_done_o}, 32'h0);
    check("midreset result", bus.div_result_o, 32'h0);
    check("midreset rd", {27'h0, bus.div_rd_o}, 32'h0);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.div_done_o || bus.div_busy_o) saw_done = 1'b1;
    end
    check("midreset abandoned", {31'h0, saw_done}, 32'h0);
    run_op("after_reset", 2'b00, 32'hFFFF_FFF9, 32'h2, 5'd5, 32'hFFFF_FFFD);

    // Randomized operands against the reference model
    for (int i = 0; i < 200; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), rop, ra, rb, 5'($urandom), ref_div(rop, ra, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
